// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer
//   Buffers stereo sample pairs written on CLOCK_50 and shifts them out
//   left-justified to a codec that is master of AUD_BCLK / AUD_DACLRCK.
//
// Ports
//   CLOCK_50                 system clock (rising edge)
//   reset_n                  asynchronous active-low reset
//   clear_audio_out_memory   synchronous flush of the sample buffer
//   left/right_channel_audio_out  32-bit MSB-aligned samples
//   write_audio_out          push one pair (dropped when buffer full)
//   audio_out_allowed        buffer not full
//   AUD_BCLK, AUD_DACLRCK    codec clocks, asynchronous to CLOCK_50
//   AUD_DACDAT               serial data to codec DAC
//   fifo_used                buffer occupancy
//   underflow                one-cycle pulse: frame started with empty buffer
module audio_dac_serializer #(
    parameter int AUDIO_DATA_WIDTH = 24,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic                          clear_audio_out_memory,
    input  logic [31:0]                   left_channel_audio_out,
    input  logic [31:0]                   right_channel_audio_out,
    input  logic                          write_audio_out,
    output logic                          audio_out_allowed,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_DACLRCK,
    output logic                          AUD_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_used,
    output logic                          underflow
);
    localparam int W  = AUDIO_DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(W + 1);
    localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(FIFO_DEPTH);
    localparam logic [BW-1:0] WORD_BITS = BW'(W);

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t state, state_nxt;

    // ---------------- codec clock synchronizers ----------------
    logic       bclk_s1, bclk_s2, bclk_h;
    logic       lrck_s1, lrck_s2, lrck_h;
    logic [1:0] warm;     // edges ignored until history flop holds real data
    logic       sync_ok, bclk_fall, lrck_rise, lrck_fall;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            {bclk_s1, bclk_s2, bclk_h} <= '0;
            {lrck_s1, lrck_s2, lrck_h} <= '0;
            warm                       <= '0;
        end else begin
            bclk_s1 <= AUD_BCLK;
            bclk_s2 <= bclk_s1;
            bclk_h  <= bclk_s2;
            lrck_s1 <= AUD_DACLRCK;
            lrck_s2 <= lrck_s1;
            lrck_h  <= lrck_s2;
            if (warm != 2'd3) warm <= warm + 2'd1;
        end
    end

    // Without the warm-up gate a high LRCK at reset release would look
    // like a rising edge and start output mid-frame.
    assign sync_ok   = (warm == 2'd3);
    assign bclk_fall = sync_ok &  bclk_h & ~bclk_s2;
    assign lrck_rise = sync_ok & ~lrck_h &  lrck_s2;
    assign lrck_fall = sync_ok &  lrck_h & ~lrck_s2;

    // ---------------- sample FIFO ----------------
    logic [63:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [63:0]   head;
    logic          have_data, push, pop;

    assign audio_out_allowed = (fifo_used != FULL_CNT);
    assign have_data = (fifo_used != '0);
    assign head      = mem[rd_ptr];
    assign push      = write_audio_out & audio_out_allowed & ~clear_audio_out_memory;
    // Pop uses the registered count, so a same-cycle write into an empty
    // buffer is stored but not seen by this frame.
    assign pop       = lrck_rise & have_data;

    always_ff @(posedge CLOCK_50) begin
        if (push) mem[wr_ptr] <= {left_channel_audio_out, right_channel_audio_out};
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_used <= '0;
        end else if (clear_audio_out_memory) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_used <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      fifo_used <= fifo_used + 1'b1;
            else if (pop && !push) fifo_used <= fifo_used - 1'b1;
        end
    end

    // ---------------- channel state machine ----------------
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (lrck_rise) state_nxt = LEFT;
            LEFT:    if (lrck_fall) state_nxt = RIGHT;
            RIGHT:   if (lrck_rise) state_nxt = LEFT;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- holding / shift registers ----------------
    logic [31:0]   left_hold, right_hold;
    logic [W-1:0]  shift;
    logic [BW-1:0] bit_cnt;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            left_hold  <= '0;
            right_hold <= '0;
            shift      <= '0;
            bit_cnt    <= '0;
            underflow  <= 1'b0;
        end else begin
            underflow <= lrck_rise & ~have_data;
            if (lrck_rise) begin
                // The left word goes straight from the FIFO head into the
                // shift register so its MSB is out without an extra cycle.
                left_hold  <= have_data ? head[63:32] : '0;
                right_hold <= have_data ? head[31:0]  : '0;
                shift      <= have_data ? head[63:64-W] : '0;
                bit_cnt    <= '0;
            end else if (lrck_fall && state == LEFT) begin
                shift   <= right_hold[31:32-W];
                bit_cnt <= '0;
            end else if (bclk_fall && state != IDLE && bit_cnt != WORD_BITS) begin
                shift   <= {shift[W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign AUD_DACDAT = (state != IDLE) && (bit_cnt != WORD_BITS) && shift[W-1];

    // Low sample bits and the left copy are kept for completeness only.
    logic unused_bits;
    assign unused_bits = ^{head, left_hold, right_hold};

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: drives codec clocks (BCLK = 64 x LRCK,
// 4 CLOCK_50 cycles per BCLK half period) and checks every serial bit at
// each BCLK rising edge against a queue-based model of the sample buffer.
module tb_audio_dac_serializer;
    localparam int W     = 24;
    localparam int DEPTH = 4;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b1;
    logic        clr = 1'b0, wr = 1'b0, bclk = 1'b1, lrck = 1'b0;
    logic [31:0] l_in = '0, r_in = '0;
    logic        allowed, dacdat, uf;
    logic [2:0]  used;

    int          checks = 0, failures = 0;
    int          uf_cnt = 0;
    bit          dut_active = 0;
    logic [63:0] q[$];

    audio_dac_serializer #(.AUDIO_DATA_WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .clear_audio_out_memory(clr),
        .left_channel_audio_out(l_in), .right_channel_audio_out(r_in),
        .write_audio_out(wr), .audio_out_allowed(allowed), .AUD_BCLK(bclk),
        .AUD_DACLRCK(lrck), .AUD_DACDAT(dacdat), .fifo_used(used), .underflow(uf)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) if (uf === 1'b1) uf_cnt++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic waitn(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic check_level();
        check("fifo_used", 32'(used), 32'(q.size()));
        check("allowed", 32'(allowed), 32'(q.size() != DEPTH));
    endtask

    task automatic push(input logic [31:0] l, input logic [31:0] r);
        @(negedge CLOCK_50);
        wr = 1'b1; l_in = l; r_in = r;
        @(negedge CLOCK_50);
        wr = 1'b0;
        if (q.size() < DEPTH) q.push_back({l, r});
        check_level();
    endtask

    // One LRCK half: nbits BCLK periods; the bit present just before each
    // BCLK rise is compared with the model word (only W MSBs are sent).
    task automatic run_half(input logic lr, input logic [31:0] word, input int nbits,
                            input int clr_at, input int rst_at, output logic [31:0] got);
        logic [31:0] exp_w;
        got   = '0;
        exp_w = (word >> (32 - W)) << (32 - W);
        for (int k = 0; k < nbits; k++) begin
            bclk = 1'b0;
            if (k == 0) lrck = lr;
            waitn(4);
            got[31-k] = dacdat;
            check($sformatf("bit_%s%0d", lr ? "L" : "R", k), 32'(dacdat),
                  dut_active ? 32'(exp_w[31-k]) : 32'd0);
            bclk = 1'b1;
            if (k == clr_at) begin
                @(negedge CLOCK_50);
                clr = 1'b1; wr = 1'b1; l_in = $urandom; r_in = $urandom;
                @(negedge CLOCK_50);
                clr = 1'b0; wr = 1'b0;
                q.delete();
                check("clear_used", 32'(used), 32'd0);
                waitn(2);
            end else if (k == rst_at) begin
                #2 reset_n = 1'b0;
                #1;
                check("rst_dacdat", 32'(dacdat), 32'd0);
                check("rst_used", 32'(used), 32'd0);
                check("rst_allowed", 32'(allowed), 32'd1);
                @(negedge CLOCK_50);
                reset_n = 1'b1;
                q.delete();
                dut_active = 0;
                waitn(3);
            end else begin
                waitn(4);
            end
        end
    endtask

    task automatic frame(input int lbits, input int clr_at, input int rst_at,
                         output logic [31:0] gl, output logic [31:0] gr);
        logic [63:0] p;
        int          uf0;
        bit          empty;
        empty = (q.size() == 0);
        p     = '0;
        if (!empty) p = q.pop_front();
        dut_active = 1;
        uf0 = uf_cnt;
        run_half(1'b1, p[63:32], lbits, clr_at, rst_at, gl);
        run_half(1'b0, p[31:0], 32, -1, -1, gr);
        check("underflow_pulses", 32'(uf_cnt - uf0), 32'(empty));
        check_level();
    endtask

    initial begin
        logic [31:0] gl, gr;
        #2 reset_n = 1'b0;
        waitn(3);
        check("reset_used", 32'(used), 32'd0);
        check("reset_allowed", 32'(allowed), 32'd1);
        check("reset_dacdat", 32'(dacdat), 32'd0);
        check("reset_underflow", 32'(uf), 32'd0);
        reset_n = 1'b1;
        waitn(5);

        // Known pattern, 24-bit words followed by zeros.
        push(32'hA5A5_A500, 32'h5A5A_5A00);
        frame(32, -1, -1, gl, gr);
        check("lit_left", gl, 32'hA5A5_A500);
        check("lit_right", gr, 32'h5A5A_5A00);

        // Empty buffer: single underflow pulse, silent frame.
        frame(32, -1, -1, gl, gr);
        check("uf_left", gl, 32'd0);
        check("uf_right", gr, 32'd0);

        // Overfill: fifth pair dropped, then pairs drain in order.
        for (int i = 0; i < 5; i++) push($urandom, $urandom);
        check("full_used", 32'(used), 32'd4);
        check("full_allowed", 32'(allowed), 32'd0);
        for (int i = 0; i < 4; i++) frame(32, -1, -1, gl, gr);

        // Flush with a same-cycle write while a frame is being sent.
        for (int i = 0; i < 4; i++) push($urandom, $urandom);
        frame(32, 8, -1, gl, gr);

        // Short left word: right channel starts at once.
        push($urandom, $urandom | 32'h8000_0000);
        push($urandom, $urandom);
        frame(10, -1, -1, gl, gr);
        frame(32, -1, -1, gl, gr);

        // Reset in the middle of the left word.
        for (int i = 0; i < 3; i++) push($urandom, $urandom);
        frame(32, -1, 5, gl, gr);
        push(32'hFFFF_FF00, 32'h8000_0100);
        frame(32, -1, -1, gl, gr);
        check("post_rst_left", gl, 32'hFFFF_FF00);
        check("post_rst_right", gr, 32'h8000_0100);

        // Randomized traffic.
        for (int n = 0; n < 10; n++) begin
            int np;
            np = $urandom_range(0, 3);
            for (int i = 0; i < np; i++) push($urandom, $urandom);
            frame(($urandom_range(0, 3) == 0) ? $urandom_range(8, 31) : 32, -1, -1, gl, gr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
